tdp_ram_be_sc: RTL and testbench

- Parametrised single-clock true dual-port RAM with per-byte write enables and a selectable read-during-write mode.
- Adds an optional output register stage, per-port read-valid flags, same-address collision arbitration and detection, and a hardware clear sequencer that zeroes the array after reset or on request.
- Used as the storage core for the team's sync FIFOs and shared scratch buffers.

---
 rtl/tdp_ram_pkg.sv | 51 +++++
 rtl/tdp_ram_outstage.sv | 54 +++++
 rtl/tdp_ram_be_sc.sv | 231 +++++++++++++++++++++++
 tb/tb_tdp_ram_be_sc.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tdp_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdp_ram_pkg
// Description : Shared types and helpers for the tdp_ram_be_sc RAM core:
//               read-during-write mode enum, clear-sequencer state enum and
//               a width-agnostic byte-merge function.
// Revision    : 1.0 - initial release
// ============================================================================
package tdp_ram_pkg;

  // Same-port read-during-write behaviour.
  typedef enum logic [1:0] {
    WRITE_FIRST = 2'd0,
    READ_FIRST  = 2'd1,
    NO_CHANGE   = 2'd2
  } rdw_mode_e;

  // Clear sequencer states.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  // Upper bounds for the merge helper. Callers zero-extend their words and
  // masks to these widths and truncate the result back.
  localparam int c_MAX_DW  = 256;
  localparam int c_MAX_NB  = 32;
  localparam int c_LANE_W  = $clog2(c_MAX_NB);

  // Returns i_old with every lane whose enable bit is set replaced by the
  // matching lane of i_new. i_bw is the lane width in bits and must be > 0.
  function automatic logic [c_MAX_DW-1:0] byte_merge(
    input logic [c_MAX_DW-1:0] i_old,
    input logic [c_MAX_DW-1:0] i_new,
    input logic [c_MAX_NB-1:0] i_be,
    input int                  i_bw
  );
    logic [c_MAX_DW-1:0] w_res;
    int                  w_lane;
    w_res = i_old;
    for (int k = 0; k < c_MAX_DW; k++) begin
      w_lane = k / i_bw;
      if ((w_lane < c_MAX_NB) && i_be[w_lane[c_LANE_W-1:0]]) begin
        w_res[k] = i_new[k];
      end
    end
    return w_res;
  endfunction

endpackage : tdp_ram_pkg
`default_nettype wire

// File: rtl/tdp_ram_outstage.sv
`default_nettype none
// ============================================================================
// Module      : tdp_ram_outstage
// Description : Optional output pipeline register for one RAM read port.
//               OUT_REG = 0 passes data/valid straight through; OUT_REG = 1
//               adds one register (reset to 0). Data only loads on valid so
//               the output holds its last value between accesses.
// Ports       : i_clk    - clock
//               i_rst_n  - asynchronous active-low reset
//               i_data   - read data from the first stage
//               i_valid  - read-valid from the first stage
//               o_data   - read data to the port
//               o_valid  - read-valid pulse to the port
// Revision    : 1.0 - initial release
// ============================================================================
module tdp_ram_outstage #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
);

  if (OUT_REG != 0) begin : g_reg
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= i_valid;
        if (i_valid) begin
          r_data <= i_data;
        end
      end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
  end else begin : g_bypass
    logic w_unused_clk;
    assign w_unused_clk = i_clk ^ i_rst_n;
    assign o_data  = i_data;
    assign o_valid = i_valid;
  end

endmodule : tdp_ram_outstage
`default_nettype wire

// File: rtl/tdp_ram_be_sc.sv
`default_nettype none
// ============================================================================
// Module      : tdp_ram_be_sc
// Description : Single-clock true dual-port RAM with byte write enables,
//               selectable same-port read-during-write mode, optional output
//               register, same-address collision arbitration/detection and a
//               clear sequencer that zeroes the array after reset or on
//               request.
// Ports       : i_clk / i_rst_n          - clock, async active-low reset
//               i_clear                   - request to zero the array (READY)
//               o_ready                   - accesses accepted
//               o_collision(_sticky)      - collision pulse / latched flag
//               i_en_x, i_we_x            - access enable, byte write enables
//               i_addr_x, i_data_x        - word address, write data
//               o_data_x, o_valid_x       - read data, read-valid pulse
// Revision    : 1.0 - initial release
// ============================================================================
module tdp_ram_be_sc
  import tdp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_clear,
  output logic                             o_ready,
  output logic                             o_collision,
  output logic                             o_collision_sticky,
  input  logic                             i_en_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_we_a,
  input  logic [ADDR_WIDTH-1:0]            i_addr_a,
  input  logic [DATA_WIDTH-1:0]            i_data_a,
  output logic [DATA_WIDTH-1:0]            o_data_a,
  output logic                             o_valid_a,
  input  logic                             i_en_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_we_b,
  input  logic [ADDR_WIDTH-1:0]            i_addr_b,
  input  logic [DATA_WIDTH-1:0]            i_data_b,
  output logic [DATA_WIDTH-1:0]            o_data_b,
  output logic                             o_valid_b
);

  localparam int                    c_NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int                    c_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_LAST  = '1;
  localparam logic [ADDR_WIDTH-1:0] c_ONE   = 1;
  localparam rdw_mode_e             c_RDW   = rdw_mode_e'(RDW_MODE[1:0]);

  function automatic logic [DATA_WIDTH-1:0] merge_w(
    input logic [DATA_WIDTH-1:0] i_old,
    input logic [DATA_WIDTH-1:0] i_new,
    input logic [c_NB-1:0]       i_be
  );
    logic [c_MAX_DW-1:0] w_res;
    w_res = byte_merge(c_MAX_DW'(i_old), c_MAX_DW'(i_new), c_MAX_NB'(i_be), BYTE_WIDTH);
    return w_res[DATA_WIDTH-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

  clr_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  r_ready;
  logic                  r_coll;
  logic                  r_coll_sticky;

  // --------------------------------------------------------------------------
  // Access decode and collision arbitration
  // --------------------------------------------------------------------------
  logic [1:0]            w_acc;
  logic [1:0]            w_wr;
  logic                  w_same;
  logic                  w_coll;
  logic [DATA_WIDTH-1:0] w_old   [2];
  logic [DATA_WIDTH-1:0] w_fin   [2];
  logic [DATA_WIDTH-1:0] w_new_a;
  logic [DATA_WIDTH-1:0] w_new_b;
  logic [DATA_WIDTH-1:0] w_odat  [2];
  logic [1:0]            w_ovld;

  assign w_acc[0] = r_ready & i_en_a;
  assign w_acc[1] = r_ready & i_en_b;
  assign w_wr[0]  = w_acc[0] & (|i_we_a);
  assign w_wr[1]  = w_acc[1] & (|i_we_b);
  assign w_same   = w_acc[0] & w_acc[1] & (i_addr_a == i_addr_b);
  assign w_coll   = w_same & (|w_wr);

  assign w_old[0] = r_mem[i_addr_a];
  assign w_old[1] = r_mem[i_addr_b];

  // On a shared address B's bytes are applied first and A's on top, so A
  // wins overlapping lanes and w_new_a is the final stored word.
  assign w_new_b  = merge_w(w_old[1], i_data_b, i_we_b);
  assign w_new_a  = merge_w(w_same ? w_new_b : w_old[0], i_data_a, i_we_a);
  assign w_fin[0] = w_new_a;
  assign w_fin[1] = w_same ? w_new_a : w_new_b;

  // --------------------------------------------------------------------------
  // Array: clear writes while sequencing, otherwise at most one write per
  // distinct address (a shared address is written once with the merged word)
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (r_state == CLEAR) begin
      r_mem[r_clr_cnt] <= '0;
    end else begin
      if (w_wr[1] && !w_same) begin
        r_mem[i_addr_b] <= w_new_b;
      end
      if (w_wr[0] || (w_same && w_wr[1])) begin
        r_mem[i_addr_a] <= w_new_a;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Clear sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= CLEAR;
      r_clr_cnt     <= '0;
      r_ready       <= 1'b0;
      r_coll_sticky <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + c_ONE;
          if (r_clr_cnt == c_LAST) begin
            r_state <= READY;
            r_ready <= 1'b1;
          end
        end
        READY: begin
          if (i_clear) begin
            r_state       <= CLEAR;
            r_ready       <= 1'b0;
            r_coll_sticky <= 1'b0;
          end else if (w_coll) begin
            r_coll_sticky <= 1'b1;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_coll <= 1'b0;
    end else begin
      r_coll <= w_coll;
    end
  end

  // --------------------------------------------------------------------------
  // Per-port read path
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_WIDTH-1:0] w_rd_dat;
    logic                  w_rd_vld;
    logic [DATA_WIDTH-1:0] r_s1_dat;
    logic                  r_s1_vld;

    // A cross-port read of a location being written sees w_old, i.e. the
    // pre-write word, since the array updates only at the clock edge.
    always_comb begin
      w_rd_vld = 1'b0;
      w_rd_dat = w_old[p];
      if (w_acc[p]) begin
        if (w_wr[p]) begin
          case (c_RDW)
            WRITE_FIRST: begin
              w_rd_vld = 1'b1;
              w_rd_dat = w_fin[p];
            end
            READ_FIRST: begin
              w_rd_vld = 1'b1;
              w_rd_dat = w_old[p];
            end
            default: begin
              w_rd_vld = 1'b0;
            end
          endcase
        end else begin
          w_rd_vld = 1'b1;
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_s1_dat <= '0;
        r_s1_vld <= 1'b0;
      end else begin
        r_s1_vld <= w_rd_vld;
        if (w_rd_vld) begin
          r_s1_dat <= w_rd_dat;
        end
      end
    end

    tdp_ram_outstage #(
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_REG    (OUT_REG)
    ) u_outstage (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_data  (r_s1_dat),
      .i_valid (r_s1_vld),
      .o_data  (w_odat[p]),
      .o_valid (w_ovld[p])
    );
  end

  assign o_ready            = r_ready;
  assign o_collision        = r_coll;
  assign o_collision_sticky = r_coll_sticky;
  assign o_data_a           = w_odat[0];
  assign o_valid_a          = w_ovld[0];
  assign o_data_b           = w_odat[1];
  assign o_valid_b          = w_ovld[1];

endmodule : tdp_ram_be_sc
`default_nettype wire

// File: tb/tb_tdp_ram_be_sc.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdp_ram_be_sc
// Description : Directed self-checking bench for tdp_ram_be_sc. Four copies
//               share one stimulus: [0] WRITE_FIRST, [1] READ_FIRST,
//               [2] NO_CHANGE (all OUT_REG=0) and [3] WRITE_FIRST, OUT_REG=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdp_ram_be_sc;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        clear  = 1'b0;
  logic        en_a   = 1'b0;
  logic        en_b   = 1'b0;
  logic [3:0]  we_a   = '0;
  logic [3:0]  we_b   = '0;
  logic [3:0]  addr_a = '0;
  logic [3:0]  addr_b = '0;
  logic [31:0] din_a  = '0;
  logic [31:0] din_b  = '0;

  logic [31:0] dout_a [4];
  logic [31:0] dout_b [4];
  logic        ready  [4];
  logic        coll   [4];
  logic        sticky [4];
  logic        vld_a  [4];
  logic        vld_b  [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    tdp_ram_be_sc #(
      .DATA_WIDTH (32),
      .BYTE_WIDTH (8),
      .ADDR_WIDTH (4),
      .RDW_MODE   ((g == 3) ? 0 : g),
      .OUT_REG    ((g == 3) ? 1 : 0)
    ) u_dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_clear            (clear),
      .o_ready            (ready[g]),
      .o_collision        (coll[g]),
      .o_collision_sticky (sticky[g]),
      .i_en_a             (en_a),
      .i_we_a             (we_a),
      .i_addr_a           (addr_a),
      .i_data_a           (din_a),
      .o_data_a           (dout_a[g]),
      .o_valid_a          (vld_a[g]),
      .i_en_b             (en_b),
      .i_we_b             (we_b),
      .i_addr_b           (addr_b),
      .i_data_b           (din_b),
      .o_data_b           (dout_b[g]),
      .o_valid_b          (vld_b[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    en_a = 1'b0;
    en_b = 1'b0;
    we_a = '0;
    we_b = '0;
  endtask

  task automatic acc_a(input logic [3:0] we, input logic [3:0] a, input logic [31:0] d);
    en_a = 1'b1; we_a = we; addr_a = a; din_a = d;
  endtask

  task automatic acc_b(input logic [3:0] we, input logic [3:0] a, input logic [31:0] d);
    en_b = 1'b1; we_b = we; addr_b = a; din_b = d;
  endtask

  // Counts clock edges until ready rises; bounded so a stuck DUT still ends.
  task automatic wait_ready(input string tag, input int exp);
    int n;
    n = 0;
    while (!ready[0] && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    // ---------------- reset state ----------------
    idle();
    repeat (3) tick();
    chk("rst_ready",  32'(ready[0]),  32'd0);
    chk("rst_vld_a",  32'(vld_a[0]),  32'd0);
    chk("rst_sticky", 32'(sticky[0]), 32'd0);
    chk("rst_dout_a3", dout_a[3],     32'd0);

    // ---------------- first clear after reset; port must be ignored -------
    rst_n = 1'b1;
    acc_a(4'hF, 4'd1, 32'hFFFF_FFFF);
    wait_ready("clear_len_reset", 16);
    idle();
    chk("clear_ignores_port", 32'(vld_a[0]), 32'd0);

    for (int i = 0; i < 16; i++) begin
      acc_a(4'h0, 4'(i), 32'd0);
      tick();
      chk($sformatf("init_rd%0d", i), dout_a[0], 32'd0);
    end
    chk("init_rd_vld", 32'(vld_a[0]), 32'd1);

    // ---------------- read-during-write modes ----------------
    acc_a(4'hF, 4'd3, 32'hDEAD_BEEF);
    tick();
    chk("wf1_d", dout_a[0], 32'hDEAD_BEEF);
    chk("rf1_d", dout_a[1], 32'h0000_0000);
    chk("nc1_v", 32'(vld_a[2]), 32'd0);

    acc_a(4'b0011, 4'd3, 32'h1122_3344);
    tick();
    chk("wf2_d", dout_a[0], 32'hDEAD_3344);
    chk("wf2_v", 32'(vld_a[0]), 32'd1);
    chk("rf2_d", dout_a[1], 32'hDEAD_BEEF);
    chk("rf2_v", 32'(vld_a[1]), 32'd1);
    chk("nc2_d", dout_a[2], 32'h0000_0000);
    chk("nc2_v", 32'(vld_a[2]), 32'd0);
    chk("oreg1_d", dout_a[3], 32'hDEAD_BEEF);
    chk("oreg1_v", 32'(vld_a[3]), 32'd1);

    idle();
    tick();
    chk("hold_d", dout_a[0], 32'hDEAD_3344);
    chk("hold_v", 32'(vld_a[0]), 32'd0);
    chk("oreg2_d", dout_a[3], 32'hDEAD_3344);

    acc_a(4'h0, 4'd3, 32'd0);
    tick();
    chk("rd3_wf", dout_a[0], 32'hDEAD_3344);
    chk("rd3_rf", dout_a[1], 32'hDEAD_3344);
    chk("rd3_nc", dout_a[2], 32'hDEAD_3344);
    chk("rd3_nc_v", 32'(vld_a[2]), 32'd1);
    chk("oreg3_v", 32'(vld_a[3]), 32'd0);
    idle();
    tick();

    // ---------------- write/write collision ----------------
    acc_a(4'b1100, 4'd5, 32'hAAAA_AAAA);
    acc_b(4'b0110, 4'd5, 32'h5555_5555);
    tick();
    chk("ww_coll",   32'(coll[0]),   32'd1);
    chk("ww_sticky", 32'(sticky[0]), 32'd1);
    chk("ww_da",     dout_a[0], 32'hAAAA_5500);
    chk("ww_db",     dout_b[0], 32'hAAAA_5500);
    chk("ww_db_rf",  dout_b[1], 32'h0000_0000);
    idle();
    tick();
    chk("ww_coll_pulse", 32'(coll[0]),   32'd0);
    chk("ww_sticky_hold", 32'(sticky[0]), 32'd1);
    acc_a(4'h0, 4'd5, 32'd0);
    tick();
    chk("ww_mem5", dout_a[0], 32'hAAAA_5500);

    // ---------------- write/read collision ----------------
    idle();
    acc_a(4'hF, 4'd7, 32'h1234_5678);
    acc_b(4'h0, 4'd7, 32'd0);
    tick();
    chk("xr_db",     dout_b[0], 32'h0000_0000);
    chk("xr_vb",     32'(vld_b[0]), 32'd1);
    chk("xr_coll",   32'(coll[0]), 32'd1);
    chk("xr_da",     dout_a[0], 32'h1234_5678);
    chk("xr_or_vb0", 32'(vld_b[3]), 32'd0);
    idle();
    tick();
    chk("xr_or_vb1", 32'(vld_b[3]), 32'd1);
    chk("xr_or_db",  dout_b[3], 32'h0000_0000);
    chk("xr_or_sticky", 32'(sticky[3]), 32'd1);

    // ---------------- read/read same address ----------------
    acc_a(4'h0, 4'd5, 32'd0);
    acc_b(4'h0, 4'd5, 32'd0);
    tick();
    chk("rr_da",   dout_a[0], 32'hAAAA_5500);
    chk("rr_db",   dout_b[0], 32'hAAAA_5500);
    chk("rr_coll", 32'(coll[0]), 32'd0);
    idle();

    // ---------------- fill, then requested clear ----------------
    for (int i = 0; i < 16; i++) begin
      acc_a(4'hF, 4'(i), 32'hA5A5_0000 | 32'(i));
      tick();
    end
    acc_a(4'h0, 4'd3, 32'd0);
    tick();
    chk("fill_rd3", dout_a[0], 32'hA5A5_0003);
    idle();

    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_ready",  32'(ready[0]),  32'd0);
    chk("clr_sticky", 32'(sticky[0]), 32'd0);
    chk("clr_hold",   dout_a[0], 32'hA5A5_0003);
    wait_ready("clear_len_req", 16);
    for (int i = 0; i < 16; i++) begin
      acc_a(4'h0, 4'(i), 32'd0);
      tick();
      chk($sformatf("clr_rd%0d", i), dout_a[0], 32'd0);
    end
    idle();

    // ---------------- reset in the middle of a clear ----------------
    acc_a(4'hF, 4'd2, 32'hCAFE_F00D);
    tick();
    acc_a(4'h0, 4'd2, 32'd0);
    tick();
    chk("pre_rst_rd2", dout_a[0], 32'hCAFE_F00D);
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (5) tick();
    chk("midclr_ready", 32'(ready[0]), 32'd0);
    chk("midclr_hold3", dout_a[3], 32'hCAFE_F00D);
    rst_n = 1'b0;
    #1;
    chk("rst_async_da",  dout_a[0], 32'd0);
    chk("rst_async_da3", dout_a[3], 32'd0);
    #2;
    rst_n = 1'b1;
    wait_ready("clear_len_rst2", 16);
    acc_a(4'h0, 4'd2, 32'd0);
    tick();
    chk("post_rst_rd2", dout_a[0], 32'd0);
    chk("post_rst_v",   32'(vld_a[0]), 32'd1);
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_tdp_ram_be_sc
`default_nettype wire
